// File: rtl/button_event_classifier.sv
`default_nettype none
// ============================================================================
// Module   : button_event_classifier
// Purpose  : Turns a clean, clk-synchronous push-button level into one-cycle
//            event pulses: press, short press, long press and double press.
//            It also provides a held level and a wrapping 8-bit press counter.
//            All outputs are registered.
// Ports    : clk          - system clock (single domain)
//            rst          - synchronous active-high reset
//            btn_in       - debounced button level (polarity set by ACTIVE_LOW)
//            press_pulse  - one-cycle pulse on every press edge
//            short_pulse  - one-cycle pulse for a lone press released before long
//            long_pulse   - one-cycle pulse when a first press is held LONG_CLKS
//            double_pulse - one-cycle pulse on the second press of a double
//            held         - high while the classifier considers the button pressed
//            press_count  - count of press_pulse events, wraps 255 -> 0
// Revision : 1.0 - initial release
// ============================================================================
module button_event_classifier #(
    parameter logic        ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = 24,
    parameter int unsigned LONG_CLKS       = 16000000,
    parameter int unsigned DOUBLE_GAP_CLKS = 4000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       press_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       double_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    // State encoding
    localparam logic [2:0] c_IDLE           = 3'd0;
    localparam logic [2:0] c_PRESSED        = 3'd1;
    localparam logic [2:0] c_LONG_HELD      = 3'd2;
    localparam logic [2:0] c_WAIT_SECOND    = 3'd3;
    localparam logic [2:0] c_SECOND_PRESSED = 3'd4;

    // Counter values on which the long / gap decisions are taken
    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CLKS - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(DOUBLE_GAP_CLKS - 1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_p_prev;
    logic             r_press_pulse;
    logic             r_short_pulse;
    logic             r_long_pulse;
    logic             r_double_pulse;
    logic             r_held;
    logic [7:0]       r_press_count;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_p;
    logic             w_press_edge;
    logic             w_release_edge;
    logic             w_press;
    logic             w_short;
    logic             w_long;
    logic             w_double;
    logic             w_held_nxt;

    // Normalised pressed level: 1 means the button is pressed.
    assign w_p            = btn_in ^ ACTIVE_LOW;
    assign w_press_edge   = w_p & ~r_p_prev;
    assign w_release_edge = ~w_p & r_p_prev;

    // Saturating increment so an out-of-range count can never wrap back
    // onto a decision value.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : (r_cnt + c_CNT_ONE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_double    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_press_edge) begin
                    w_state_nxt = c_PRESSED;
                    w_cnt_nxt   = c_CNT_ZERO;
                    w_press     = 1'b1;
                end
            end
            c_PRESSED: begin
                // A release on the threshold cycle takes priority over long.
                if (w_release_edge) begin
                    w_state_nxt = c_WAIT_SECOND;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if ((r_cnt == c_LONG_LAST) && w_p) begin
                        w_state_nxt = c_LONG_HELD;
                        w_long      = 1'b1;
                    end
                end
            end
            c_LONG_HELD: begin
                if (w_release_edge) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_WAIT_SECOND: begin
                // A press on the expiry cycle takes priority over short.
                if (w_press_edge) begin
                    w_state_nxt = c_SECOND_PRESSED;
                    w_cnt_nxt   = c_CNT_ZERO;
                    w_press     = 1'b1;
                    w_double    = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_cnt == c_GAP_LAST) begin
                        w_state_nxt = c_IDLE;
                        w_short     = 1'b1;
                    end
                end
            end
            c_SECOND_PRESSED: begin
                if (w_release_edge) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = c_CNT_ZERO;
            end
        endcase
    end

    assign w_held_nxt = (w_state_nxt == c_PRESSED)   ||
                        (w_state_nxt == c_LONG_HELD) ||
                        (w_state_nxt == c_SECOND_PRESSED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_cnt          <= c_CNT_ZERO;
            r_p_prev       <= 1'b0;
            r_press_pulse  <= 1'b0;
            r_short_pulse  <= 1'b0;
            r_long_pulse   <= 1'b0;
            r_double_pulse <= 1'b0;
            r_held         <= 1'b0;
            r_press_count  <= 8'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_p_prev       <= w_p;
            r_press_pulse  <= w_press;
            r_short_pulse  <= w_short;
            r_long_pulse   <= w_long;
            r_double_pulse <= w_double;
            r_held         <= w_held_nxt;
            if (w_press) begin
                r_press_count <= r_press_count + 8'd1;
            end
        end
    end

    assign press_pulse  = r_press_pulse;
    assign short_pulse  = r_short_pulse;
    assign long_pulse   = r_long_pulse;
    assign double_pulse = r_double_pulse;
    assign held         = r_held;
    assign press_count  = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_button_event_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_classifier
// Purpose  : Self-checking bench for button_event_classifier. Directed button
//            sequences push the events they must cause (kind, cycle, count)
//            into a queue; a monitor pops and compares each observed pulse.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_classifier;

    localparam int c_EV_PRESS  = 0;
    localparam int c_EV_DOUBLE = 1;
    localparam int c_EV_SHORT  = 2;
    localparam int c_EV_LONG   = 3;
    localparam int c_LONG      = 20;
    localparam int c_GAP       = 10;

    typedef struct {
        int         kind;
        int         at;
        logic [7:0] cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b1;
    logic       press_pulse;
    logic       short_pulse;
    logic       long_pulse;
    logic       double_pulse;
    logic       held;
    logic [7:0] press_count;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_count = 8'd0;
    ev_t        exp_q[$];

    button_event_classifier #(
        .ACTIVE_LOW      (1'b1),
        .CNT_W           (24),
        .LONG_CLKS       (c_LONG),
        .DOUBLE_GAP_CLKS (c_GAP)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .press_pulse  (press_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .double_pulse (double_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        if (kind == c_EV_PRESS) exp_count = exp_count + 8'd1;
        e.kind = kind;
        e.at   = at;
        e.cnt  = exp_count;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic observe(input int kind);
        ev_t e;
        check("event_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_cycle", 32'(cyc), 32'(e.at));
            if (kind == c_EV_PRESS) check("press_count", 32'(press_count), 32'(e.cnt));
        end
    endtask

    // Pulses are sampled on the falling edge, half a cycle after they settle.
    always @(negedge clk) begin
        if (press_pulse)  observe(c_EV_PRESS);
        if (double_pulse) observe(c_EV_DOUBLE);
        if (short_pulse)  observe(c_EV_SHORT);
        if (long_pulse)   observe(c_EV_LONG);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_press"},  32'(press_pulse),  32'd0);
        check({tag, "_short"},  32'(short_pulse),  32'd0);
        check({tag, "_long"},   32'(long_pulse),   32'd0);
        check({tag, "_double"}, 32'(double_pulse), 32'd0);
        check({tag, "_held"},   32'(held),         32'd0);
        check({tag, "_count"},  32'(press_count),  32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        btn_in = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(3);

        // Short press: 5 cycles low, short 10 cycles after held falls
        btn_in = 1'b0;
        push(c_EV_PRESS, cyc + 1);
        tick(5);
        check("short_held_on", 32'(held), 32'd1);
        btn_in = 1'b1;
        push(c_EV_SHORT, cyc + 1 + c_GAP);
        tick(1);
        check("short_held_off", 32'(held), 32'd0);
        tick(15);

        // Long press: 30 cycles low, long 20 cycles after the press pulse
        btn_in = 1'b0;
        push(c_EV_PRESS, cyc + 1);
        push(c_EV_LONG, cyc + 1 + c_LONG);
        tick(30);
        check("long_held_on", 32'(held), 32'd1);
        btn_in = 1'b1;
        tick(1);
        check("long_held_off", 32'(held), 32'd0);
        tick(15);

        // Threshold tie: release detected while cnt == LONG-1
        btn_in = 1'b0;
        push(c_EV_PRESS, cyc + 1);
        tick(c_LONG);
        btn_in = 1'b1;
        push(c_EV_SHORT, cyc + 1 + c_GAP);
        tick(15);

        // Double press: 3 low, 4 high, low again
        btn_in = 1'b0;
        push(c_EV_PRESS, cyc + 1);
        tick(3);
        btn_in = 1'b1;
        tick(4);
        btn_in = 1'b0;
        push(c_EV_PRESS, cyc + 1);
        push(c_EV_DOUBLE, cyc + 1);
        tick(3);
        btn_in = 1'b1;
        tick(1);
        check("double_held_off", 32'(held), 32'd0);
        tick(15);

        // Gap tie: second press detected while cnt == GAP-1
        btn_in = 1'b0;
        push(c_EV_PRESS, cyc + 1);
        tick(3);
        btn_in = 1'b1;
        tick(c_GAP);
        btn_in = 1'b0;
        push(c_EV_PRESS, cyc + 1);
        push(c_EV_DOUBLE, cyc + 1);
        tick(2);
        btn_in = 1'b1;
        tick(15);

        // Reset while PRESSED: everything clears and no event follows
        btn_in = 1'b0;
        push(c_EV_PRESS, cyc + 1);
        tick(5);
        rst = 1'b1;
        btn_in = 1'b1;
        tick(1);
        check_all_zero("mid_reset");
        rst = 1'b0;
        exp_count = 8'd0;
        tick(25);

        // Button held through reset release: press on first post-reset cycle
        btn_in = 1'b0;
        push(c_EV_PRESS, cyc + 1);
        tick(3);
        rst = 1'b1;
        tick(2);
        check("held_rst_held", 32'(held), 32'd0);
        check("held_rst_count", 32'(press_count), 32'd0);
        rst = 1'b0;
        exp_count = 8'd0;
        push(c_EV_PRESS, cyc + 1);
        tick(2);
        btn_in = 1'b1;
        push(c_EV_SHORT, cyc + 1 + c_GAP);
        tick(15);

        // 256 presses from a cleared counter: count wraps back to 0
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_count = 8'd0;
        for (int i = 0; i < 256; i++) begin
            btn_in = 1'b0;
            push(c_EV_PRESS, cyc + 1);
            if ((i % 2) == 1) push(c_EV_DOUBLE, cyc + 1);
            tick(1);
            btn_in = 1'b1;
            tick(1);
        end
        tick(15);
        check("wrap_count", 32'(press_count), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_event_classifier.md
# button_event_classifier

Downstream consumer of the debounced push-button level from the input debouncer, clocked by the same 16 MHz `clk`. It turns the clean level into single-cycle event pulses: press, short press, long press and double press. It also provides a held level and a wrapping press counter for the application logic. All outputs are registered.

## Interface
Parameters:
- `ACTIVE_LOW`, 1: 1 means `btn_in` low = pressed (pull-up button); 0 means high = pressed.
- `CNT_W`, 24: width of the internal duration counter.
- `LONG_CLKS`, 16000000: hold duration that qualifies as a long press (1 s at 16 MHz). Must be ≥2 and <2^CNT_W.
- `DOUBLE_GAP_CLKS`, 4000000: maximum release-to-press gap for a double press (250 ms). Must be ≥2 and <2^CNT_W.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `rst` input 1: synchronous, active-high reset.
- `btn_in` input 1: debounced button level, already synchronous to `clk`.
- `press_pulse` output 1: one-cycle pulse on every press edge.
- `short_pulse` output 1: one-cycle pulse; single press, released before long, with no second press in the gap.
- `long_pulse` output 1: one-cycle pulse when the hold reaches `LONG_CLKS`.
- `double_pulse` output 1: one-cycle pulse on the second press of a double press.
- `held` output 1: level, high while the FSM considers the button pressed.
- `press_count` output 8: count of `press_pulse` events, wraps 255→0.

## Operation
- `p` is the normalized pressed level: `btn_in` XOR `ACTIVE_LOW`.
- `p_prev` is the registered `p`.
- Press edge is `p & ~p_prev`. Release edge is `~p & p_prev`.
- Reset loads `p_prev` = 0 (released). A button held through reset therefore yields a press edge on the first cycle after reset.
- FSM states: IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED.
- IDLE:
  - Press edge → PRESSED, `cnt` ← 0, `press_pulse`, `press_count`+1.
- PRESSED (`cnt` +1 per cycle, saturating):
  - Release edge → WAIT_SECOND, `cnt` ← 0.
  - Otherwise, `cnt` == `LONG_CLKS`-1 and still pressed → LONG_HELD, `long_pulse`.
  - Release on the threshold cycle wins: no long, go to WAIT_SECOND.
- LONG_HELD:
  - Release edge → IDLE. No short or double is ever emitted for this press.
- WAIT_SECOND (`cnt` +1 per cycle):
  - Press edge → SECOND_PRESSED, `double_pulse`, `press_pulse`, `press_count`+1.
  - Otherwise, `cnt` == `DOUBLE_GAP_CLKS`-1 → IDLE, `short_pulse`.
  - Press on the expiry cycle wins: double, no short.
- SECOND_PRESSED:
  - Release edge → IDLE. A long hold of the second press produces no `long_pulse`.
- `held` = 1 in PRESSED, LONG_HELD and SECOND_PRESSED.
- At most one of `short_pulse`, `long_pulse`, `double_pulse` is high in any cycle. `press_pulse` may coincide with `double_pulse`.
- Reset mid-operation:
  - FSM → IDLE, `cnt` ← 0, `press_count` ← 0.
  - All pulses deasserted in the cycle after the reset edge.
  - Any pending short, long or double decision is discarded; no event is emitted for it.

## Timing
- Reset values: `press_pulse`, `short_pulse`, `long_pulse`, `double_pulse`, `held` all 0; `press_count` 0.
- `btn_in` press seen at edge k (sampled into `p_prev` there) → `press_pulse` and `held` high in cycle k+1.
- `long_pulse` asserts exactly `LONG_CLKS` cycles after `press_pulse`, provided the button stays pressed.
- Release: release edge detected at edge r → `held` low in cycle r+1.
- Short decision: `short_pulse` asserts `DOUBLE_GAP_CLKS` cycles after `held` falls.
- Double: `double_pulse` has the same one-cycle latency from the second press edge as `press_pulse`.
- Every pulse is exactly one cycle wide.

## Test plan
Bench parameters: `LONG_CLKS`=20, `DOUBLE_GAP_CLKS`=10, `ACTIVE_LOW`=1.
- Short press: hold `btn_in` low 5 cycles, then high.
  - `press_pulse` 1 cycle after the fall.
  - `short_pulse` exactly 10 cycles after `held` falls.
  - `press_count`=1; no long or double pulse.
- Long press: hold low 30 cycles.
  - `long_pulse` exactly 20 cycles after `press_pulse`.
  - `held` stays high until release.
  - No `short_pulse` after release.
- Threshold tie: release on the cycle `cnt`=19.
  - No `long_pulse`; `short_pulse` 10 cycles after release.
- Double press: press 3 cycles, release 4 cycles, press again.
  - `double_pulse` coincides with the second `press_pulse`.
  - `press_count`=2; no `short_pulse`.
- Gap tie: second press lands on the expiry cycle (`cnt`=9).
  - `double_pulse`; no `short_pulse`.
- Reset and wrap:
  - Assert `rst` during PRESSED: all outputs 0 next cycle, and no event follows.
  - Hold `btn_in` low through reset release: `press_pulse` on the first post-reset cycle.
  - 256 presses: `press_count` wraps to 0.
